// File: rtl/mod241_mul_seq_if.sv
// Operand/result handshake bundle for the sequential mod-241 multiplier.
interface mod241_mul_seq_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mod241_mul_seq.sv
// Sequential (a*b) mod 241: MSB-first double-and-add over b, one bit per cycle,
// with every intermediate kept reduced below MOD.
module mod241_mul_seq #(
  parameter int unsigned MOD = 241,
  parameter int unsigned W   = 8
) (
  input logic            clk,
  input logic            rst,
  mod241_mul_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned W1 = W + 1;
  localparam logic [W-1:0] MOD_W = W'(MOD);
  localparam logic [W:0]   MOD_X = W1'(MOD);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic [W:0]    w_dbl;
  logic [W-1:0]  w_t;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_sum_red;
  logic [W-1:0]  w_u;
  logic [W-1:0]  w_a_in;
  logic [W-1:0]  w_b_in;

  // Inputs may be up to 255; a single subtract brings them into 0..240.
  assign w_a_in = (bus.a >= MOD_W) ? W'(bus.a - MOD_W) : bus.a;
  assign w_b_in = (bus.b >= MOD_W) ? W'(bus.b - MOD_W) : bus.b;

  // One double-and-add step; both add operands are < MOD so one subtract suffices.
  assign w_dbl     = {r_acc, 1'b0};
  assign w_t       = (w_dbl >= MOD_X) ? W'(w_dbl - MOD_X) : w_dbl[W-1:0];
  assign w_sum     = {1'b0, w_t} + {1'b0, r_a};
  assign w_sum_red = (w_sum >= MOD_X) ? W'(w_sum - MOD_X) : w_sum[W-1:0];
  assign w_u       = r_b[r_cnt] ? w_sum_red : w_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= w_a_in;
            r_b        <= w_b_in;
            r_acc      <= '0;
            r_cnt      <= CNT_TOP;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_u;
          if (r_cnt == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_acc;

endmodule

// File: tb/tb_mod241_mul_seq.sv
// Directed and swept checks of mod241_mul_seq: results, 9-cycle latency,
// backpressure, ignored inputs and asynchronous reset mid-operation.
module tb_mod241_mul_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mod241_mul_seq_if #(.W(8)) bus ();

  mod241_mul_seq #(.MOD(241), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation; returns the result seen on out_valid and the number
  // of edges from the accept edge (inclusive) until out_valid is seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input int stall,
                        output logic [7:0] res, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.a = ta;
    bus.b = tb_v;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.result !== 8'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] res;
    int lat;
    run_op(8'd2, 8'd3, 0, res, lat);
    checks++;
    if (res !== 8'd6) begin errors++; $display("FAIL basic_2x3 got=%0d exp=6", res); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_post_handshake got rdy=%b vld=%b busy=%b exp 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
    end
    run_op(8'd16, 8'd16, 0, res, lat);
    checks++;
    if (res !== 8'd15) begin errors++; $display("FAIL basic_16x16 got=%0d exp=15", res); end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [8] = '{8'd240, 8'd0,   8'd1,   8'd120, 8'd121, 8'd255, 8'd241, 8'd250};
    logic [7:0] vb [8] = '{8'd240, 8'd200, 8'd240, 8'd2,   8'd2,   8'd2,   8'd77,  8'd250};
    logic [7:0] ve [8] = '{8'd1,   8'd0,   8'd240, 8'd240, 8'd1,   8'd28,  8'd0,   8'd81};
    logic [7:0] res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], 0, res, lat);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL boundary_%0dx%0d got=%0d exp=%0d", va[i], vb[i], res, ve[i]);
      end
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL boundary_latency got=%0d exp=9", lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.a = 8'd16;
    bus.b = 8'd16;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL backpressure_latency got=%0d exp=9", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 8'd15) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got vld=%b res=%0d exp vld=1 res=15", i, bus.out_valid, bus.result);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got vld=%b rdy=%b exp 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_ignore_in_run();
    int lat;
    bus.a = 8'd7;
    bus.b = 8'd9;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Keep offering a different pair and assert out_ready while running.
    bus.a = 8'd200;
    bus.b = 8'd100;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_run_flags got rdy=%b busy=%b exp 0 1", bus.in_ready, bus.busy);
    end
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
    checks++;
    if (bus.result !== 8'd63) begin errors++; $display("FAIL ignore_result got=%0d exp=63", bus.result); end
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_accept_in_done got rdy=%b vld=%b exp 0 1", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ignore_after_handshake got rdy=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res;
    int lat;
    int t0;
    int t1;
    t0 = 0;
    run_op(8'd3, 8'd4, 0, res, lat);
    checks++;
    if (res !== 8'd12) begin errors++; $display("FAIL b2b_first got=%0d exp=12", res); end
    run_op(8'd100, 8'd3, 0, res, lat);
    t1 = lat;
    checks++;
    if (res !== 8'd59 || t1 !== 9) begin
      errors++;
      $display("FAIL b2b_second got res=%0d lat=%0d exp res=59 lat=9", res, t1);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || t0 !== 0) begin
      errors++;
      $display("FAIL b2b_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] res;
    int lat;
    bus.a = 8'd200;
    bus.b = 8'd200;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run got vld=%b rdy=%b busy=%b exp 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
    #2;
    rst = 1'b0;
    run_op(8'd3, 8'd5, 0, res, lat);
    checks++;
    if (res !== 8'd15 || lat !== 9) begin
      errors++;
      $display("FAIL reset_recover got res=%0d lat=%0d exp res=15 lat=9", res, lat);
    end
  endtask

  task automatic test_random_sweep();
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] res;
    logic [7:0] exp_v;
    int lat;
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_v = 8'((int'(ra) * int'(rb)) % 241);
      run_op(ra, rb, int'($urandom_range(0, 2)), res, lat);
      checks++;
      if (res !== exp_v || lat !== 9) begin
        errors++;
        $display("FAIL sweep_%0dx%0d got res=%0d lat=%0d exp res=%0d lat=9", ra, rb, res, lat, exp_v);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
